// File: rtl/pwm_bank_pkg.sv
// Shared constants and address-decode helper for the pwm_bank_ctrl PWM bank.
// The duty update mode is selected by the PWM_SHADOW_UPDATE_EN macro, which pwm_bank_channel reads.
package pwm_bank_pkg;

  localparam int unsigned DUTY_W      = 8;
  localparam logic [6:0]  ADDR_OUT_EN = 7'h00;
  localparam logic [6:0]  ADDR_PWM_EN = 7'h08;
  localparam logic [6:0]  ADDR_DUTY   = 7'h20;
  localparam logic [7:0]  CNT_MAX     = 8'd254;
  localparam logic [7:0]  DUTY_FULL   = 8'hFF;

  // True when addr falls inside the per-channel duty window.
  function automatic logic is_duty_addr(input logic [31:0] addr, input int unsigned num_ch);
    return (addr >= 32'(ADDR_DUTY)) && (addr < 32'(ADDR_DUTY) + num_ch);
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: duty register(s), compare against the shared period counter, output mux and flop.
// With PWM_SHADOW_UPDATE_EN defined, duty writes are staged and applied only at period wrap.
module pwm_bank_channel
  import pwm_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_hit,
  input  logic [DUTY_W-1:0] wr_data,
  input  logic              wrap,
  input  logic [7:0]        cnt,
  input  logic              out_en,
  input  logic              pwm_en,
  output logic              pwm_o
);

  logic [DUTY_W-1:0] duty_act;
  logic              raw;
  logic              mux;

`ifdef PWM_SHADOW_UPDATE_EN
  logic [DUTY_W-1:0] duty_sh;

  // A write coinciding with wrap goes straight to the active duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
    end else begin
      if (wr_hit) duty_sh <= wr_data;
      if (wrap) duty_act <= wr_hit ? wr_data : duty_sh;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_act <= '0;
    end else if (wr_hit) begin
      duty_act <= wr_data;
    end
  end
`endif

  always_comb begin
    raw = (duty_act == DUTY_FULL) ? 1'b1 : (cnt < duty_act);
    mux = 1'b0;
    if (out_en) mux = pwm_en ? raw : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_o <= 1'b0;
    else     pwm_o <= mux;
  end

endmodule

// File: rtl/pwm_bank_ctrl.sv
// N-channel PWM bank: prescaler, shared period counter, register decode and per-channel instances.
// Build option: define PWM_SHADOW_UPDATE_EN for period-synchronous duty updates.
module pwm_bank_ctrl
  import pwm_bank_pkg::*;
#(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned PRESCALE = 3000,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_end
);

  localparam int unsigned NUM_BYTES = NUM_CH / 8;
  localparam int unsigned PRESC_W   = $clog2(PRESCALE);

  logic [1:0]           rst_q;
  logic                 rst_i;
  logic [PRESC_W-1:0]   presc;
  logic [7:0]           cnt;
  logic                 tick;
  logic                 wrap;
  logic                 mapped;
  logic [NUM_BYTES-1:0] oe_hit;
  logic [NUM_BYTES-1:0] pe_hit;
  logic [NUM_CH-1:0]    duty_hit;
  logic [NUM_CH-1:0]    out_en;
  logic [NUM_CH-1:0]    pwm_en;

  // Reset asserts immediately, releases two clocks later in step with clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_q <= 2'b11;
    else     rst_q <= {rst_q[0], 1'b0};
  end
  assign rst_i = rst_q[1];

  assign tick = (presc == PRESC_W'(PRESCALE - 1));
  assign wrap = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      presc      <= '0;
      cnt        <= '0;
      period_end <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + PRESC_W'(1);
      if (tick) cnt <= wrap ? '0 : cnt + 8'd1;
      period_end <= wrap;
      wr_err     <= wr_en && !mapped;
    end
  end

  assign mapped = (|oe_hit) || (|pe_hit) || is_duty_addr(32'(wr_addr), NUM_CH);

  // Enable registers, one byte of out_en and pwm_en per address.
  for (genvar gb = 0; gb < NUM_BYTES; gb++) begin : g_byte
    logic [7:0] oe_q;
    logic [7:0] pe_q;

    assign oe_hit[gb] = wr_en && (32'(wr_addr) == 32'(ADDR_OUT_EN) + 32'(gb));
    assign pe_hit[gb] = wr_en && (32'(wr_addr) == 32'(ADDR_PWM_EN) + 32'(gb));

    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        oe_q <= '0;
        pe_q <= '0;
      end else begin
        if (oe_hit[gb]) oe_q <= wr_data;
        if (pe_hit[gb]) pe_q <= wr_data;
      end
    end

    assign out_en[8*gb +: 8] = oe_q;
    assign pwm_en[8*gb +: 8] = pe_q;
  end

  for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
    assign duty_hit[gc] = wr_en && (32'(wr_addr) == 32'(ADDR_DUTY) + 32'(gc));

    pwm_bank_channel u_ch (
      .clk     (clk),
      .rst     (rst_i),
      .wr_hit  (duty_hit[gc]),
      .wr_data (wr_data),
      .wrap    (wrap),
      .cnt     (cnt),
      .out_en  (out_en[gc]),
      .pwm_en  (pwm_en[gc]),
      .pwm_o   (pwm_out[gc])
    );
  end

endmodule

// File: tb/tb_pwm_bank_ctrl.sv
// Testbench for pwm_bank_ctrl: directed steps plus random register writes against a timing model.
module tb_pwm_bank_ctrl;

  localparam int unsigned NUM_CH   = 16;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned PERIOD   = 255 * PRESCALE;
  localparam int unsigned NB       = NUM_CH / 8;
`ifdef PWM_SHADOW_UPDATE_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk     = 1'b0;
  logic              rst     = 1'b1;
  logic              wr_en   = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [7:0]        wr_data = '0;
  logic              wr_err;
  logic              period_end;
  logic [NUM_CH-1:0] pwm_out;

  int checks = 0;
  int errors = 0;

  // Model: k = clock edges since the internal reset released; hold = edges still in reset sync.
  int unsigned k    = 0;
  int unsigned hold = 0;
  bit m_oe [NUM_CH];
  bit m_pe [NUM_CH];
  int m_duty [NUM_CH];
  int m_sh   [NUM_CH];
  int hi     [NUM_CH];
  int pe_seen = 0;

  pwm_bank_ctrl #(.NUM_CH(NUM_CH), .PRESCALE(PRESCALE), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_now();
    return int'((k / PRESCALE) % 255);
  endfunction

  function automatic bit is_mapped(input int a);
    return (a < int'(NB)) || (a >= 8 && a < 8 + int'(NB)) || (a >= 32 && a < 32 + int'(NUM_CH));
  endfunction

  function automatic logic [NUM_CH-1:0] expect_out();
    logic [NUM_CH-1:0] v;
    int c;
    v = '0;
    c = cnt_now();
    for (int ch = 0; ch < int'(NUM_CH); ch++)
      if (m_oe[ch]) v[ch] = !m_pe[ch] ? 1'b1 : ((m_duty[ch] == 255) ? 1'b1 : (c < m_duty[ch]));
    return v;
  endfunction

  task automatic model_reset();
    k = 0;
    hold = 2;
    for (int ch = 0; ch < int'(NUM_CH); ch++) begin
      m_oe[ch] = 1'b0; m_pe[ch] = 1'b0; m_duty[ch] = 0; m_sh[ch] = 0;
    end
  endtask

  task automatic clear_hi();
    for (int ch = 0; ch < int'(NUM_CH); ch++) hi[ch] = 0;
    pe_seen = 0;
  endtask

  task automatic apply_write(input int addr, input int data, input bit wrap_edge);
    logic [7:0] d;
    d = 8'(data);
    if (addr < int'(NB)) begin
      for (int b = 0; b < 8; b++) m_oe[8*addr + b] = d[b];
    end else if (addr >= 8 && addr < 8 + int'(NB)) begin
      for (int b = 0; b < 8; b++) m_pe[8*(addr-8) + b] = d[b];
    end else if (addr >= 32 && addr < 32 + int'(NUM_CH)) begin
      m_sh[addr-32] = int'(d);
      if (!SHADOW || wrap_edge) m_duty[addr-32] = int'(d);
    end
  endtask

  // One clock: drive inputs, predict, advance the model, compare all outputs.
  task automatic step(input bit we, input int addr, input int data);
    logic [NUM_CH-1:0] e_out;
    bit e_pe, e_err, wrap_edge;
    wr_en   = we;
    wr_addr = ADDR_W'(addr);
    wr_data = 8'(data);
    if (hold > 0) begin
      e_out = '0; e_pe = 1'b0; e_err = 1'b0;
    end else begin
      e_out = expect_out();
      e_pe  = ((k + 1) % PERIOD) == 0;
      e_err = we && !is_mapped(addr);
    end
    @(posedge clk);
    #1;
    if (hold > 0) begin
      hold--;
    end else begin
      k++;
      wrap_edge = (k % PERIOD) == 0;
      if (SHADOW && wrap_edge)
        for (int ch = 0; ch < int'(NUM_CH); ch++) m_duty[ch] = m_sh[ch];
      if (we) apply_write(addr, data, wrap_edge);
    end
    wr_en = 1'b0;
    chk("pwm_out", 64'(pwm_out), 64'(e_out));
    chk("period_end", 64'(period_end), 64'(e_pe));
    chk("wr_err", 64'(wr_err), 64'(e_err));
    for (int ch = 0; ch < int'(NUM_CH); ch++) if (pwm_out[ch]) hi[ch]++;
    if (period_end) pe_seen++;
  endtask

  task automatic idle();
    step(1'b0, 0, 0);
  endtask

  initial begin
    int a, r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm_out", 64'(pwm_out), 64'd0);
    chk("rst_period_end", 64'(period_end), 64'd0);
    chk("rst_wr_err", 64'(wr_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    idle();

    // out_en only: channel forced high on the second edge after the write
    step(1'b1, 0, 8'h02);
    chk("oe_only_edge1", 64'(pwm_out[1]), 64'd0);
    idle();
    chk("oe_only_edge2", 64'(pwm_out[1]), 64'd1);

    step(1'b1, 0, 8'hFF);
    step(1'b1, 1, 8'hF7);
    step(1'b1, 8, 8'hFF);
    step(1'b1, 9, 8'h0F);
    step(1'b1, 32, 8'h80);
    step(1'b1, 33, 8'h00);
    step(1'b1, 34, 8'hFF);
    step(1'b1, 43, 8'h55);
    for (int ch = 3; ch <= 10; ch++) step(1'b1, 32 + ch, int'($urandom_range(0, 255)));

    while (k % PERIOD != 0) idle();
    clear_hi();
    repeat (2 * PERIOD) idle();
    chk("duty80_high_clk", 64'(hi[0]), 64'(2 * 512));
    chk("duty00_high_clk", 64'(hi[1]), 64'd0);
    chk("dutyFF_high_clk", 64'(hi[2]), 64'(2 * PERIOD));
    chk("oe_off_high_clk", 64'(hi[11]), 64'd0);
    chk("pwm_off_high_clk", 64'(hi[12]), 64'(2 * PERIOD));
    chk("period_end_count", 64'(pe_seen), 64'd2);

    step(1'b1, 8'h15, 8'hAA);
    chk("unmapped_15_err", 64'(wr_err), 64'd1);
    idle();
    chk("unmapped_err_clear", 64'(wr_err), 64'd0);
    step(1'b1, 8'h03, 8'h00);
    chk("unmapped_03_err", 64'(wr_err), 64'd1);

    // Duty write landing exactly on the wrap edge is used for the new period
    while ((k + 1) % PERIOD != 0) idle();
    step(1'b1, 32, 8'h10);
    clear_hi();
    do idle(); while (k % PERIOD != 0);
    chk("wrap_write_high_clk", 64'(hi[0]), 64'(16 * PRESCALE));

    // Mid-period duty change at cnt=100
    while ((k + 1) % PERIOD != 0) idle();
    step(1'b1, 32, 8'h40);
    clear_hi();
    while (!((k % PRESCALE) == 0 && cnt_now() == 100)) idle();
    step(1'b1, 32, 8'hC0);
    while (k % PERIOD != 0) idle();
    chk("midperiod_high_clk", 64'(hi[0]), SHADOW ? 64'd256 : 64'd623);
    clear_hi();
    repeat (PERIOD) idle();
    chk("next_period_high_clk", 64'(hi[0]), 64'(192 * PRESCALE));

    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(0, 3));
        case (r)
          0:       a = int'($urandom_range(0, NB - 1));
          1:       a = 8 + int'($urandom_range(0, NB - 1));
          2:       a = 32 + int'($urandom_range(0, NUM_CH - 1));
          default: a = int'($urandom_range(0, 127));
        endcase
        step(1'b1, a, int'($urandom_range(0, 255)));
      end else begin
        idle();
      end
    end

    // Asynchronous reset mid-period with channels driven high
    step(1'b1, 0, 8'hFF);
    step(1'b1, 8, 8'h00);
    idle();
    while (cnt_now() != 200) idle();
    chk("pre_rst_high", 64'(pwm_out[2]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm_out", 64'(pwm_out), 64'd0);
    chk("async_rst_period_end", 64'(period_end), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    idle();
    step(1'b1, 0, 8'h01);
    step(1'b1, 8, 8'h01);
    step(1'b1, 32, 8'h02);
    clear_hi();
    repeat (PERIOD + 8) idle();
    chk("post_rst_period_end", 64'(pe_seen), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
